// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one 16x16 shift-add multiplier among NREQ requesters.
// Optional abort-on-timeout in BUSY is enabled by defining MULT_ARB_TIMEOUT_EN.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    input  logic [31:0]       mul_yout,
    input  logic              mul_done,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [NREQ-1:0] GNT_LSB = {{(NREQ-1){1'b0}}, 1'b1};

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("mul_share_arb: unsupported parameter set");
    end

    logic [1:0]     state_r;
    logic [IDW-1:0] rr_ptr_r;
    logic [IDW-1:0] id_r;
    logic [31:0]    base_r;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] grant_idx_s;
    logic           grant_found_s;
    logic [15:0]    slot_a_s [NREQ];
    logic [15:0]    slot_b_s [NREQ];

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_r;
`endif

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign slot_a_s[k] = req_a[16*k +: 16];
        assign slot_b_s[k] = req_b[16*k +: 16];
    end

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
        if (g == IDW'(NREQ - 1)) begin
            return '0;
        end else begin
            return g + IDW'(1);
        end
    endfunction

    // Round-robin search: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = IDW'((int'(rr_ptr_r) + i) % NREQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            id_r      <= '0;
            base_r    <= 32'd0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= 16'd0;
            mul_b     <= 16'd0;
            busy      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            tmo_cnt_r <= 8'd0;
`endif
        end else begin
            req_ready <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        req_ready <= GNT_LSB << grant_idx_s;
                        id_r      <= grant_idx_s;
                        mul_a     <= slot_a_s[grant_idx_s];
                        mul_b     <= slot_b_s[grant_idx_s];
                        // Product register never clears, so remember where it started.
                        base_r    <= mul_yout;
                        busy      <= 1'b1;
                        state_r   <= ST_LAUNCH;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    mul_start <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                    tmo_cnt_r <= 8'd0;
`endif
                    state_r   <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        rsp_data  <= mul_yout - base_r;
                        rsp_id    <= id_r;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        mul_start <= 1'b0;
                        state_r   <= ST_RESP;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        rsp_data  <= 32'd0;
                        rsp_id    <= id_r;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        mul_start <= 1'b0;
                        state_r   <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
`else
                    else begin
                        mul_start <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    // mul_start stays low here, which re-arms the multiplier.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr_r  <= next_ptr(id_r);
                        mul_a     <= 16'd0;
                        mul_b     <= 16'd0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    mul_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
